led_key_ctrl: RTL

LED_KEY_CTRL -- requirements
Module: led_key_ctrl

---
 rtl/led_key_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/led_key_ctrl.sv
// LED run controller: two debounced push-buttons steer run direction and speed
// level, and a speed-scaled divider emits one step pulse per LED advance.

module led_key_deb #(
  parameter int unsigned DEB_CNT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic evt
);
  localparam int unsigned CNT_W = 24;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CNT, HELD, REL_CNT} deb_state_t;

  logic [1:0]       sync_q;
  logic             key_s;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_d;

  assign key_s = sync_q[1];

  // Synchronizer, FSM state, counter and event register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      evt     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt     <= evt_d;
    end
  end

  // Any sample contradicting the pending level restarts the stability count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_CNT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_CNT: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          evt_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = REL_CNT;
          cnt_d   = CNT_W'(1);
        end
      end
      REL_CNT: begin
        if (!key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end
endmodule

module led_key_ctrl #(
  parameter int unsigned DEB_CNT  = 1000000,
  parameter int unsigned BASE_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_dir_n,
  input  logic       key_spd_n,
  output logic       mode,
  output logic       step_en,
  output logic [1:0] spd_sel,
  output logic       dir_evt,
  output logic       spd_evt
);
  localparam int unsigned DIV_W = 28;
  localparam logic [DIV_W-1:0] BASE = DIV_W'(BASE_DIV);

  logic             dir_p, spd_p;
  logic [DIV_W-1:0] div_cnt, div_last;

  led_key_deb #(.DEB_CNT(DEB_CNT)) u_deb_dir (
    .clk(clk), .rst_n(rst_n), .key_n(key_dir_n), .evt(dir_p)
  );

  led_key_deb #(.DEB_CNT(DEB_CNT)) u_deb_spd (
    .clk(clk), .rst_n(rst_n), .key_n(key_spd_n), .evt(spd_p)
  );

  assign div_last = (BASE >> spd_sel) - DIV_W'(1);

  // Key events update mode/speed; a speed change restarts the step divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode    <= 1'b0;
      spd_sel <= '0;
      step_en <= 1'b0;
      dir_evt <= 1'b0;
      spd_evt <= 1'b0;
      div_cnt <= '0;
    end else begin
      dir_evt <= dir_p;
      spd_evt <= spd_p;
      if (dir_p) mode <= ~mode;
      if (spd_p) begin
        spd_sel <= spd_sel + 2'd1;
        div_cnt <= '0;
        step_en <= 1'b0;
      end else begin
        step_en <= (div_cnt == div_last);
        div_cnt <= (div_cnt >= div_last) ? '0 : div_cnt + DIV_W'(1);
      end
    end
  end
endmodule
